// File: rtl/automata_stage_report_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : automata_stage_report_pipe
//  Purpose  : Registers the symbol stream and restart control for the next
//             automata stage, and collects this stage's report vectors into
//             a timestamped first-word-fall-through FIFO with valid/ready
//             drain, sticky overflow flag and saturating drop counter.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module automata_stage_report_pipe #(
    parameter int SYM_W = 8,
    parameter int N_RPT = 44,
    parameter int DEPTH = 8,
    parameter int TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     stream_reset,
    input  logic [SYM_W-1:0]         top_symbols,
    input  logic [N_RPT-1:0]         rpt_in,
    input  logic                     ovf_clr,
    input  logic                     rpt_ready,
    output logic [SYM_W-1:0]         out_symbols,
    output logic                     out_run,
    output logic                     out_stream_reset,
    output logic                     rpt_valid,
    output logic [N_RPT-1:0]         rpt_data,
    output logic [TS_W-1:0]          rpt_ts,
    output logic [$clog2(DEPTH):0]   rpt_level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYM_W-1:0] out_symbols_q;
    logic             out_run_q;
    logic             out_stream_reset_q;

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  ts_d;

    logic [N_RPT-1:0] data_mem_q [DEPTH];
    logic [TS_W-1:0]  ts_mem_q   [DEPTH];

    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_LW-1:0]  level_q;
    logic [c_LW-1:0]  level_d;

    logic             overflow_q;
    logic             overflow_d;
    logic [15:0]      drop_cnt_q;
    logic [15:0]      drop_cnt_d;

    // ------------------------------------------------------------------
    // Push / pop decode
    // ------------------------------------------------------------------
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_drop;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == c_LW'(DEPTH));
    // Valid depends only on registered occupancy, so ready never feeds it.
    assign w_pop   = ~w_empty & rpt_ready;
    assign w_push  = run & (|rpt_in) & ~stream_reset;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Symbol pipe: symbol advances only on run, controls copy every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_symbols_q      <= '0;
            out_run_q          <= 1'b0;
            out_stream_reset_q <= 1'b0;
        end else begin
            if (run) begin
                out_symbols_q <= top_symbols;
            end
            out_run_q          <= run;
            out_stream_reset_q <= stream_reset;
        end
    end

    // Timestamp next value: restart dominates, then count consumed symbols
    always_comb begin
        ts_d = ts_q;
        if (stream_reset) begin
            ts_d = '0;
        end else if (run) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    // Timestamp register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    // Per-entry storage; each slot captures {ts, rpt_in} when it is the write target
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            // Slot i write port
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_mem_q[i] <= '0;
                    ts_mem_q[i]   <= '0;
                end else if (w_wr && (wr_ptr_q == c_AW'(i))) begin
                    data_mem_q[i] <= rpt_in;
                    ts_mem_q[i]   <= ts_q;
                end
            end
        end
    endgenerate

    // Occupancy next value: push and pop together leave the level unchanged
    always_comb begin
        level_d = level_q;
        case ({w_wr, w_pop})
            2'b10:   level_d = level_q + c_LW'(1);
            2'b01:   level_d = level_q - c_LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks full/empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Overflow bookkeeping: a drop in the clear cycle survives as a fresh count of 1
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Overflow flag and drop counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_symbols      = out_symbols_q;
    assign out_run          = out_run_q;
    assign out_stream_reset = out_stream_reset_q;
    assign rpt_valid        = ~w_empty;
    assign rpt_data         = w_empty ? '0 : data_mem_q[rd_ptr_q];
    assign rpt_ts           = w_empty ? '0 : ts_mem_q[rd_ptr_q];
    assign rpt_level        = level_q;
    assign overflow         = overflow_q;
    assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_automata_stage_report_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_automata_stage_report_pipe
//  Purpose  : Self-checking bench for automata_stage_report_pipe; expected
//             report entries are queued as stimulus is applied and compared
//             as the FIFO drains.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_automata_stage_report_pipe;

    localparam int SYM_W = 8;
    localparam int N_RPT = 44;
    localparam int DEPTH = 8;
    localparam int TS_W  = 32;
    localparam int EW    = TS_W + N_RPT;

    logic                   clk;
    logic                   reset;
    logic                   run;
    logic                   stream_reset;
    logic [SYM_W-1:0]       top_symbols;
    logic [N_RPT-1:0]       rpt_in;
    logic                   ovf_clr;
    logic                   rpt_ready;
    logic [SYM_W-1:0]       out_symbols;
    logic                   out_run;
    logic                   out_stream_reset;
    logic                   rpt_valid;
    logic [N_RPT-1:0]       rpt_data;
    logic [TS_W-1:0]        rpt_ts;
    logic [$clog2(DEPTH):0] rpt_level;
    logic                   overflow;
    logic [15:0]            drop_cnt;

    automata_stage_report_pipe #(
        .SYM_W (SYM_W),
        .N_RPT (N_RPT),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .stream_reset     (stream_reset),
        .top_symbols      (top_symbols),
        .rpt_in           (rpt_in),
        .ovf_clr          (ovf_clr),
        .rpt_ready        (rpt_ready),
        .out_symbols      (out_symbols),
        .out_run          (out_run),
        .out_stream_reset (out_stream_reset),
        .rpt_valid        (rpt_valid),
        .rpt_data         (rpt_data),
        .rpt_ts           (rpt_ts),
        .rpt_level        (rpt_level),
        .overflow         (overflow),
        .drop_cnt         (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [EW-1:0] sb[$];
    logic [EW-1:0] pop_log[$];
    logic [TS_W-1:0] m_ts;
    logic            m_ovf;
    logic [15:0]     m_drops;

    task automatic model_reset();
        sb.delete();
        m_ts    = '0;
        m_ovf   = 1'b0;
        m_drops = '0;
    endtask

    // One clock: scoreboard the pre-edge pop, predict the push, advance
    task automatic cycle();
        logic          pop;
        logic          push;
        logic          drop;
        logic [EW-1:0] exp_e;
        pop  = rpt_valid && rpt_ready;
        drop = 1'b0;
        n_checks++;
        if (rpt_valid !== (sb.size() != 0))
            $display("FAIL valid: got %0b expected %0b", rpt_valid, sb.size() != 0);
        else
            n_pass++;
        if (pop) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pop: got ts=%0d data=%h expected no entry", rpt_ts, rpt_data);
            end else begin
                exp_e = sb.pop_front();
                if ({rpt_ts, rpt_data} !== exp_e)
                    $display("FAIL head_entry: got ts=%0d data=%h expected ts=%0d data=%h",
                             rpt_ts, rpt_data, exp_e[EW-1:N_RPT], exp_e[N_RPT-1:0]);
                else
                    n_pass++;
            end
            pop_log.push_back({rpt_ts, rpt_data});
        end
        push = run && (rpt_in != '0) && !stream_reset;
        if (push) begin
            if (sb.size() < DEPTH || pop) sb.push_back({m_ts, rpt_in});
            else drop = 1'b1;
        end
        if (ovf_clr) begin
            m_ovf   = 1'b0;
            m_drops = '0;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        if (stream_reset) m_ts = '0;
        else if (run)     m_ts = m_ts + 1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rpt_level !== sb.size())
            $display("FAIL level: got %0d expected %0d", rpt_level, sb.size());
        else
            n_pass++;
        n_checks++;
        if ({overflow, drop_cnt} !== {m_ovf, m_drops})
            $display("FAIL ovf_state: got ovf=%0b drops=%0d expected ovf=%0b drops=%0d",
                     overflow, drop_cnt, m_ovf, m_drops);
        else
            n_pass++;
    endtask

    task automatic idle();
        run = 0; stream_reset = 0; rpt_in = '0; ovf_clr = 0;
    endtask

    task automatic restart_ts();
        idle();
        stream_reset = 1;
        cycle();
        stream_reset = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle(); rpt_ready = 0; top_symbols = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_symbols, out_run, out_stream_reset, rpt_valid, rpt_data, rpt_ts, rpt_level, overflow, drop_cnt} !== '0)
            $display("FAIL reset_outputs: got sym=%h run=%0b valid=%0b level=%0d expected all zero",
                     out_symbols, out_run, rpt_valid, rpt_level);
        else
            n_pass++;
        reset = 1;
    endtask

    task automatic test_passthrough();
        logic [SYM_W-1:0] syms [3];
        syms[0] = 8'h41; syms[1] = 8'h42; syms[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            run = 1; top_symbols = syms[i];
            cycle();
            n_checks++;
            if (out_symbols !== syms[i] || out_run !== 1'b1)
                $display("FAIL pass_sym: got sym=%h run=%0b expected sym=%h run=1", out_symbols, out_run, syms[i]);
            else
                n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            run = 0; top_symbols = 8'hEE;
            cycle();
            n_checks++;
            if (out_symbols !== 8'h43 || out_run !== 1'b0 || rpt_data !== '0 || rpt_ts !== '0)
                $display("FAIL pass_hold: got sym=%h run=%0b data=%h ts=%0d expected sym=43 run=0 data=0 ts=0",
                         out_symbols, out_run, rpt_data, rpt_ts);
            else
                n_pass++;
        end
        stream_reset = 1;
        cycle();
        n_checks++;
        if (out_stream_reset !== 1'b1)
            $display("FAIL pass_sr: got %0b expected 1", out_stream_reset);
        else
            n_pass++;
        stream_reset = 0;
    endtask

    task automatic test_timestamp();
        restart_ts();
        pop_log.delete();
        rpt_ready = 1;
        for (int i = 0; i < 10; i++) begin
            run = 1; top_symbols = SYM_W'(i);
            rpt_in = (i == 3 || i == 7) ? N_RPT'(1) << 5 : '0;
            cycle();
        end
        idle();
        repeat (3) cycle();
        n_checks++;
        if (pop_log.size() != 2)
            $display("FAIL ts_pop_count: got %0d expected 2", pop_log.size());
        else if (pop_log[0] !== {32'd3, 44'h20} || pop_log[1] !== {32'd7, 44'h20})
            $display("FAIL ts_values: got ts=%0d,%0d expected ts=3,7 data=20",
                     pop_log[0][EW-1:N_RPT], pop_log[1][EW-1:N_RPT]);
        else
            n_pass++;
    endtask

    task automatic test_restart();
        restart_ts();
        pop_log.delete();
        rpt_ready = 0;
        for (int i = 0; i < 5; i++) begin
            run = 1; rpt_in = (i == 4) ? N_RPT'(16) : '0;
            cycle();
        end
        run = 1; stream_reset = 1; rpt_in = N_RPT'(3);
        cycle();
        stream_reset = 0; rpt_in = N_RPT'(2);
        cycle();
        idle();
        rpt_ready = 1;
        repeat (3) cycle();
        n_checks++;
        if (pop_log.size() != 2 || pop_log[0] !== {32'd4, 44'h10} || pop_log[1] !== {32'd0, 44'h2})
            $display("FAIL restart_entries: got count=%0d expected (ts4,10) then (ts0,2)", pop_log.size());
        else
            n_pass++;
    endtask

    task automatic test_overflow();
        restart_ts();
        rpt_ready = 0;
        for (int i = 0; i < 11; i++) begin
            run = 1; rpt_in = N_RPT'(i + 1);
            cycle();
        end
        idle();
        n_checks++;
        if (rpt_level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd3 || rpt_ts !== 32'd0)
            $display("FAIL ovf_full: got level=%0d ovf=%0b drops=%0d head_ts=%0d expected 8 1 3 0",
                     rpt_level, overflow, drop_cnt, rpt_ts);
        else
            n_pass++;
        ovf_clr = 1;
        cycle();
        ovf_clr = 0;
        n_checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0)
            $display("FAIL ovf_clr: got ovf=%0b drops=%0d expected 0 0", overflow, drop_cnt);
        else
            n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [TS_W-1:0] exp_ts [11];
        for (int i = 0; i < 8; i++) exp_ts[i] = TS_W'(i);
        exp_ts[8] = 32'd11; exp_ts[9] = 32'd12; exp_ts[10] = 32'd13;
        pop_log.delete();
        rpt_ready = 1;
        for (int i = 0; i < 3; i++) begin
            run = 1; rpt_in = N_RPT'(44'hAA);
            cycle();
            n_checks++;
            if (rpt_level !== 4'd8 || drop_cnt !== 16'd0)
                $display("FAIL full_pushpop: got level=%0d drops=%0d expected 8 0", rpt_level, drop_cnt);
            else
                n_pass++;
        end
        idle();
        repeat (9) cycle();
        n_checks++;
        if (pop_log.size() != 11) begin
            $display("FAIL full_order_count: got %0d expected 11", pop_log.size());
        end else begin
            int bad;
            bad = 0;
            for (int i = 0; i < 11; i++)
                if (pop_log[i][EW-1:N_RPT] !== exp_ts[i]) bad++;
            if (bad != 0)
                $display("FAIL full_order: got %0d out-of-order entries expected 0", bad);
            else
                n_pass++;
        end
    endtask

    task automatic test_async_reset();
        restart_ts();
        rpt_ready = 0;
        for (int i = 0; i < 4; i++) begin
            run = 1; top_symbols = 8'h50 + SYM_W'(i); rpt_in = N_RPT'(i + 1);
            cycle();
        end
        idle();
        n_checks++;
        if (rpt_level !== 4'd4)
            $display("FAIL async_pre_level: got %0d expected 4", rpt_level);
        else
            n_pass++;
        #2;
        reset = 0;
        #1;
        n_checks++;
        if (rpt_valid !== 1'b0 || rpt_level !== '0 || out_symbols !== '0)
            $display("FAIL async_reset: got valid=%0b level=%0d sym=%h expected 0 0 0",
                     rpt_valid, rpt_level, out_symbols);
        else
            n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        cycle();
        n_checks++;
        if (rpt_data !== '0 || rpt_ts !== '0 || rpt_valid !== 1'b0)
            $display("FAIL async_after: got valid=%0b data=%h ts=%0d expected 0 0 0", rpt_valid, rpt_data, rpt_ts);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_timestamp();
        test_restart();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/automata_stage_report_pipe.md
# automata_stage_report_pipe

Parametrised successor to the fixed-width automata stage wrapper. It registers the symbol stream for the next stage and carries the stream-restart control alongside it. It also collects the report vector produced by that stage's automata instances into a timestamped FWFT report FIFO with valid/ready drain, overflow tracking and drop counting. It sits between consecutive automata stages of a monitor cluster; the automata instances are external and drive `rpt_in`.

## Interface
Parameters:
- `SYM_W`, 8: symbol width.
- `N_RPT`, 44: total report bits from this stage's automata.
- `DEPTH`, 8: report FIFO entries; power of two, ≥2.
- `TS_W`, 32: timestamp width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low block reset. Assertion is async; deassertion is synchronised to `clk` upstream.
- `run` in 1: symbol on `top_symbols` is consumed this cycle.
- `stream_reset` in 1: automata restart request, active-high, synchronous.
- `top_symbols` in SYM_W: input symbol.
- `rpt_in` in N_RPT: report bits for the symbol consumed this cycle; valid only when `run`=1.
- `ovf_clr` in 1: synchronous clear of `overflow` and `drop_cnt`.
- `rpt_ready` in 1: downstream accepts the head entry.
- `out_symbols` out SYM_W: registered symbol for the next stage.
- `out_run` out 1: registered `run`.
- `out_stream_reset` out 1: registered `stream_reset`.
- `rpt_valid` out 1: FIFO non-empty.
- `rpt_data` out N_RPT: head entry report vector; 0 when empty.
- `rpt_ts` out TS_W: head entry timestamp; 0 when empty.
- `rpt_level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a report entry is dropped.
- `drop_cnt` out 16: saturating count of dropped entries.

## Operation
- **Symbol pipe**
  - `out_symbols` loads `top_symbols` only when `run`=1, else holds.
  - `out_run` and `out_stream_reset` load every cycle, unconditionally.
- **Timestamp counter `ts`** (internal, TS_W bits)
  - Priority 1: `stream_reset`=1 → `ts`←0.
  - Priority 2: otherwise `run`=1 → `ts`←`ts`+1, wrapping mod 2^TS_W.
  - Otherwise hold.
  - An entry's stamp is the pre-increment value, i.e. the 0-based symbol index since the last restart.
- **Capture**
  - push = `run` & |`rpt_in` & ~`stream_reset`.
  - Pushed entry = {`ts`, `rpt_in`}.
  - `rpt_in` is ignored when `run`=0 or `stream_reset`=1.
- **Drain**
  - pop = `rpt_valid` & `rpt_ready`.
  - `rpt_data`/`rpt_ts` are driven combinationally from the head entry, forced to 0 when empty.
  - Once `rpt_valid` asserts, the head entry is stable until popped.
- **Full**
  - push with level=DEPTH and no pop → entry dropped; `overflow`←1; `drop_cnt` increments, saturating at 0xFFFF.
  - push and pop in the same cycle when full → both succeed; level unchanged; no drop.
- **Empty**: a pop is impossible because `rpt_valid`=0, so `rpt_ready` is ignored.
- **Counters and pointers**
  - `ovf_clr`=1 → `overflow`←0 and `drop_cnt`←0.
  - If a drop occurs in the same cycle as `ovf_clr`, the drop wins: `overflow`=1, `drop_cnt`=1.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally; full/empty is derived from the level counter.
- **Restart**: `stream_reset` does not flush the FIFO. Entries captured before a restart remain and drain normally.

## Timing
- Reset (`reset`=0, async): all outputs 0, FIFO empty, `ts`=0, `overflow`=0, `drop_cnt`=0. Storage is cleared.
- If reset asserts mid-operation, all state is lost immediately, including in-flight entries.
- Symbol latency: 1 cycle, `top_symbols`@k → `out_symbols`@k+1. The same holds for `out_run` and `out_stream_reset`.
- Report latency: push@k → `rpt_valid`=1 and head visible in cycle k+1 when the FIFO was empty.
- Level update:
  - `rpt_level` updates at the edge ending the cycle: +1 push only, −1 pop only, 0 for both.
  - A dropped push counts as no push.
- No combinational path from `rpt_ready` to `rpt_valid`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Reset and pass-through**
  - Stimulus: release reset; drive `run`=1 with symbols 0x41,0x42,0x43, then `run`=0 for 2 cycles.
  - Required: `out_symbols` = 0x41,0x42,0x43 one cycle later, then holds 0x43; `out_run` follows `run` delayed by 1; all report outputs stay 0 throughout.
- **Timestamping**
  - Stimulus: `run`=1 for 10 symbols with `rpt_in` bit 5 set on symbols 3 and 7, `rpt_ready`=1.
  - Required: exactly two pops, (ts=3, data=1<<5) then (ts=7, data=1<<5).
- **Restart**
  - Stimulus: 5 symbols, then `stream_reset`=1 with `run`=1 and `rpt_in`≠0, then a report on the next symbol.
  - Required: the restart-cycle report is ignored; the next entry has ts=0.
- **Overflow**
  - Stimulus: DEPTH=8, `rpt_ready`=0, 11 consecutive reporting symbols.
  - Required: `rpt_level`=8, `overflow`=1, `drop_cnt`=3; the FIFO holds ts 0..7.
  - Stimulus: then `ovf_clr` pulse.
  - Required: `overflow`=0, `drop_cnt`=0.
- **Full with simultaneous push/pop**
  - Stimulus: FIFO full, `rpt_ready`=1 and push in the same cycle.
  - Required: no drop; level stays 8; pointers wrap; output order preserved.
- **Async reset mid-stream**
  - Stimulus: assert `reset` between edges with level=4.
  - Required: `rpt_valid`, `rpt_level` and `out_symbols` go to 0 without waiting for a clock edge.
